// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store stages.
// MEM has priority; a bounded starve counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_stall,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_MEM_RD,
        OWN_MEM_WR
    } owner_t;

    owner_t          owner, owner_next;
    logic [SC_W-1:0] sc, sc_next;
    logic            if_eff;
    logic            grant_if;
    logic            grant_mem;

    always_ff @(posedge CLK) begin
        if (rst) begin
            owner <= OWN_NONE;
            sc    <= '0;
        end else begin
            owner <= owner_next;
            sc    <= sc_next;
        end
    end

    always_comb begin
        if_eff     = if_req & ~halt;
        grant_if   = if_eff & (~mem_req | (sc == SC_MAX));
        grant_mem  = mem_req & ~grant_if;

        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        owner_next = OWN_NONE;

        if (grant_if) begin
            ram_en     = 1'b1;
            ram_addr   = if_addr;
            owner_next = OWN_IF;
        end else if (grant_mem) begin
            ram_en     = 1'b1;
            ram_we     = mem_we;
            ram_addr   = mem_addr;
            ram_wdata  = mem_wdata;
            owner_next = mem_we ? OWN_MEM_WR : OWN_MEM_RD;
        end

        if_stall  = if_req & ~grant_if;
        mem_stall = mem_req & ~grant_mem;

        // Only a denied fetch can count, and it wins at SC_MAX, so sc saturates there.
        sc_next = '0;
        if (if_eff && !grant_if)
            sc_next = sc + SC_W'(1);
    end

    always_comb begin
        if_valid  = (owner == OWN_IF);
        if_rdata  = (owner == OWN_IF) ? ram_rdata : '0;
        mem_valid = (owner == OWN_MEM_RD) || (owner == OWN_MEM_WR);
        mem_rdata = (owner == OWN_MEM_RD) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x16 RAM attached.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        rst;
    logic        halt;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_stall;
    logic        if_valid;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic        load;
    logic [15:0] ram [256];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .STARVE_MAX(4)
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .halt     (halt),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_stall (if_stall),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_stall(mem_stall),
        .mem_valid(mem_valid),
        .mem_rdata(mem_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Preload pattern: word i holds 0x5000 | {i,i}, e.g. RAM[1] = 0x5101.
    function automatic logic [15:0] pat(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        return 16'h5000 | {b, b};
    endfunction

    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= pat(i);
        end else if (ram_en) begin
            if (ram_we)
                ram[ram_addr] <= ram_wdata;
            else
                ram_rdata <= ram[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge CLK);
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; halt = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        next_cycle();
        load = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rst_if_valid",  32'(if_valid),  32'h0);
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_ram_en",    32'(ram_en),    32'h0);

        // Lone fetch of RAM[1]
        if_req = 1'b1; if_addr = 8'h01;
        #1;
        chk("f1_ram_en",   32'(ram_en),   32'h1);
        chk("f1_ram_addr", 32'(ram_addr), 32'h01);
        chk("f1_ram_we",   32'(ram_we),   32'h0);
        chk("f1_if_stall", 32'(if_stall), 32'h0);
        next_cycle();
        if_req = 1'b0;
        #1;
        chk("f1_if_valid", 32'(if_valid), 32'h1);
        chk("f1_if_rdata", 32'(if_rdata), 32'h5101);
        chk("f1_if_stall", 32'(if_stall), 32'h0);
        next_cycle();
        #1;
        chk("f1_valid_pulse", 32'(if_valid), 32'h0);

        // Simultaneous write and fetch to 0x03: write first, fetch sees new data
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h03; mem_wdata = 16'h00AA;
        if_req = 1'b1; if_addr = 8'h03;
        #1;
        chk("wr_ram_we",    32'(ram_we),    32'h1);
        chk("wr_ram_addr",  32'(ram_addr),  32'h03);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'h00AA);
        chk("wr_if_stall",  32'(if_stall),  32'h1);
        chk("wr_mem_stall", 32'(mem_stall), 32'h0);
        next_cycle();
        mem_req = 1'b0; mem_we = 1'b0;
        #1;
        chk("wr_mem_valid", 32'(mem_valid), 32'h1);
        chk("wr_mem_rdata", 32'(mem_rdata), 32'h0);
        chk("wr_if_grant",  32'(if_stall),  32'h0);
        chk("wr_if_ramwe",  32'(ram_we),    32'h0);
        next_cycle();
        if_req = 1'b0;
        #1;
        chk("wr_if_valid",  32'(if_valid),  32'h1);
        chk("wr_if_rdata",  32'(if_rdata),  32'h00AA);
        chk("wr_mem_idle",  32'(mem_valid), 32'h0);

        // Starvation: MEM reads 0x10.. every cycle, fetch of 0x05 held
        if_req = 1'b1; if_addr = 8'h05;
        mem_req = 1'b1; mem_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_addr = 8'(8'h10 + k);
            #1;
            chk("st_mem_grant", 32'(mem_stall), 32'h0);
            chk("st_if_stall",  32'(if_stall),  32'h1);
            chk("st_ram_addr",  32'(ram_addr),  32'(8'h10 + k));
            if (k > 0) begin
                chk("st_mem_valid", 32'(mem_valid), 32'h1);
                chk("st_mem_rdata", 32'(mem_rdata), 32'(pat(32'h10 + k - 1)));
            end
            next_cycle();
        end
        mem_addr = 8'h14;
        #1;
        chk("st_if_win",     32'(if_stall),  32'h0);
        chk("st_mem_stall",  32'(mem_stall), 32'h1);
        chk("st_if_addr",    32'(ram_addr),  32'h05);
        chk("st_last_rdata", 32'(mem_rdata), 32'h5313);
        next_cycle();
        if_req = 1'b0;
        #1;
        chk("st_if_valid",   32'(if_valid),  32'h1);
        chk("st_if_rdata",   32'(if_rdata),  32'h5505);
        chk("st_mem_resume", 32'(mem_stall), 32'h0);
        chk("st_resume_adr", 32'(ram_addr),  32'h14);
        next_cycle();
        mem_req = 1'b0;
        #1;
        chk("st_resume_val", 32'(mem_valid), 32'h1);
        chk("st_resume_dat", 32'(mem_rdata), 32'h5414);

        // Fresh contention: sc restarted at 0, so MEM must win 4 more times
        next_cycle();
        if_req = 1'b1; if_addr = 8'h01; mem_req = 1'b1; mem_addr = 8'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sc0_mem_wins", 32'(if_stall), 32'h1);
            next_cycle();
        end
        #1;
        chk("sc0_if_wins", 32'(if_stall), 32'h0);
        next_cycle();
        if_req = 1'b0; mem_req = 1'b0;

        // Halt blocks new fetches, sc stays 0 even with MEM traffic
        next_cycle();
        halt = 1'b1; if_req = 1'b1; if_addr = 8'h02;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("h_ram_en",   32'(ram_en),   32'h0);
            chk("h_if_stall", 32'(if_stall), 32'h1);
            chk("h_if_valid", 32'(if_valid), 32'h0);
            next_cycle();
        end
        mem_req = 1'b1; mem_addr = 8'h21;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("h_mem_only", 32'(mem_stall), 32'h0);
            next_cycle();
        end
        halt = 1'b0;
        #1;
        chk("h_sc_zero", 32'(if_stall), 32'h1);
        mem_req = 1'b0;
        #1;
        chk("h_release_grant", 32'(if_stall), 32'h0);
        chk("h_release_addr",  32'(ram_addr), 32'h02);
        next_cycle();
        if_req = 1'b0;
        #1;
        chk("h_if_rdata", 32'(if_rdata), 32'h5202);

        // Fetch in flight when halt rises still returns
        next_cycle();
        if_req = 1'b1; if_addr = 8'h01;
        next_cycle();
        halt = 1'b1; if_addr = 8'h02;
        #1;
        chk("hf_if_valid", 32'(if_valid), 32'h1);
        chk("hf_if_rdata", 32'(if_rdata), 32'h5101);
        chk("hf_ram_en",   32'(ram_en),   32'h0);
        next_cycle();
        halt = 1'b0; if_req = 1'b0;
        #1;
        chk("hf_no_valid", 32'(if_valid), 32'h0);

        // Grant issued during reset is discarded
        next_cycle();
        rst = 1'b1; if_req = 1'b1; if_addr = 8'h01;
        #1;
        chk("r_comb_en", 32'(ram_en), 32'h1);
        next_cycle();
        rst = 1'b0; if_req = 1'b0;
        #1;
        chk("r_if_valid",  32'(if_valid),  32'h0);
        chk("r_mem_valid", 32'(mem_valid), 32'h0);

        // Back-to-back MEM reads of 0..3
        next_cycle();
        mem_req = 1'b1; mem_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_addr = 8'(k);
            #1;
            chk("bb_grant", 32'(mem_stall), 32'h0);
            chk("bb_if_idle", 32'(if_valid), 32'h0);
            if (k == 1) chk("bb_rdata0", 32'(mem_rdata), 32'h5000);
            if (k == 2) chk("bb_rdata1", 32'(mem_rdata), 32'h5101);
            if (k == 3) chk("bb_rdata2", 32'(mem_rdata), 32'h5202);
            if (k > 0)  chk("bb_valid",  32'(mem_valid), 32'h1);
            next_cycle();
        end
        mem_req = 1'b0;
        #1;
        chk("bb_valid3", 32'(mem_valid), 32'h1);
        chk("bb_rdata3", 32'(mem_rdata), 32'h00AA);
        next_cycle();
        #1;
        chk("bb_end_valid", 32'(mem_valid), 32'h0);
        chk("bb_end_rdata", 32'(mem_rdata), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the instruction-fetch stage and the memory (load/store) stage of the 16-bit CPU. At most one RAM access is issued per cycle. The block returns read data with fixed 1-cycle latency, signals stalls to the losing requester, and prevents fetch starvation with a bounded-wait counter. It sits between fetch_module/memory_module and the RAM macro, and blocks new fetches once the CPU halts.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 16, RAM word width (one instruction or data word)
STARVE_MAX, 4, max consecutive cycles a requesting fetch may be denied before it wins

Ports:
CLK  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
halt  in  1  CPU halted; fetch requests ignored while high
if_req  in  1  fetch read request, held with if_addr until granted
if_addr  in  ADDR_W  fetch word address
if_stall  out  1  fetch request not granted this cycle
if_valid  out  1  fetch read data valid (cycle after grant)
if_rdata  out  DATA_W  fetch read data
mem_req  in  1  data request, held with addr/we/wdata until granted
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_W  data word address
mem_wdata  in  DATA_W  write data
mem_stall  out  1  data request not granted this cycle
mem_valid  out  1  read data valid or write ack (cycle after grant)
mem_rdata  out  DATA_W  data read data; 0 on write ack
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0

Behaviour:
- Effective fetch request: if_eff = if_req & ~halt.
- Grant is combinational from the current requests and the registered starve count (sc):
  - only mem_req: grant MEM.
  - only if_eff: grant IF.
  - both: grant MEM, unless sc == STARVE_MAX, in which case grant IF.
  - neither: no grant; ram_en=0, ram_we=0, ram_addr/ram_wdata=0.
- RAM drive for IF grant: ram_en=1, ram_we=0, ram_addr=if_addr, ram_wdata=0.
- RAM drive for MEM grant: ram_en=1, ram_we=mem_we, ram_addr=mem_addr, ram_wdata=mem_wdata.
- Stall outputs: if_stall = if_req & ~grant_if (true also while halted); mem_stall = mem_req & ~grant_mem. A request is consumed in the cycle it is granted and must not be held afterwards.
- Starve counter sc (width clog2(STARVE_MAX+1)):
  - increments when if_eff=1 and IF is not granted;
  - clears to 0 when IF is granted, when if_eff=0, or on rst.
  - sc never exceeds STARVE_MAX.
- Owner register, one of {NONE, IF, MEM_RD, MEM_WR}, records the grant of the previous cycle.
- Response in cycle N+1 for a grant in cycle N:
  - IF: if_valid=1, if_rdata=ram_rdata.
  - MEM_RD: mem_valid=1, mem_rdata=ram_rdata.
  - MEM_WR: mem_valid=1, mem_rdata=0.
  - Otherwise valid=0 and rdata=0 on that side. Each valid is a single-cycle pulse per grant.
  - Back-to-back grants give back-to-back valids, for full throughput.
- Reset: owner=NONE, sc=0, so if_valid=mem_valid=0 in the first cycle after rst. Combinational outputs still follow inputs during rst, but owner is forced NONE at the rst edge. A grant issued in the same cycle as rst is discarded (no valid the next cycle).
- halt asserted while a fetch is in flight: that fetch still returns if_valid next cycle. No new IF grants while halt=1. sc stays at 0.
- Same-address simultaneous requests: MEM wins by default; a fetch granted later sees the written data.

Test Plan:
- Reset then if_req=1, if_addr=0x01, mem_req=0, RAM[1]=0x5101 -> ram_en=1 cycle 0; if_valid=1, if_rdata=0x5101 cycle 1; if_stall=0 throughout.
- mem_req=1, mem_we=1, mem_addr=0x03, mem_wdata=0x00AA together with if_req=1 at if_addr=0x03 -> cycle 0 MEM write with if_stall=1; cycle 1 mem_valid=1, mem_rdata=0, IF granted; cycle 2 if_valid=1, if_rdata=0x00AA.
- Continuous mem_req with new reads every cycle and if_req held, STARVE_MAX=4 -> MEM granted cycles 0-3 (sc reaches 4); IF granted cycle 4 with mem_stall=1; sc=0 at cycle 5; MEM resumes.
- halt=1 with if_req=1 and no mem_req -> ram_en=0, if_stall=1, if_valid never asserts, sc stays 0; halt=0 -> IF granted the same cycle.
- IF read granted at cycle 0 with rst=1 asserted in cycle 0 -> if_valid=0 at cycle 1; owner NONE; sc=0.
- Alternating mem reads (addr 0..3) and idle fetch -> mem_valid a pulse each cycle after a grant, mem_rdata = RAM[0..3] in order; if_valid stays 0.
